ex_div_unit: RTL and testbench

Iterative RV32M divide/remainder unit in the EX stage, directly downstream of the ID/EX pipeline register. It consumes the DIV-class instruction latched there, together with forwarded rs1/rs2 operands, and computes the result in 32 iteration cycles using radix-2 restoring division. While it runs it holds the front of the pipeline through `o_busy`, which is ORed into the ID/EX and IF/ID stall inputs. It presents the result for one cycle so that EX/MEM captures it.

---
 rtl/ex_div_unit.sv | 203 ++++++++++++++++++++
 tb/tb_ex_div_unit.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_div_unit.sv
// ex_div_unit
//   Iterative RV32M divide/remainder unit for the EX stage. A DIV-class
//   instruction waiting in ID/EX is accepted on i_start. The unit then runs
//   XLEN cycles of radix-2 restoring division on the operand magnitudes and
//   applies the RISC-V sign rules to the result. While it works, o_busy stalls
//   the front of the pipeline. The result is shown for one cycle with o_done
//   so that EX/MEM can capture it.
//
// Ports
//   i_clk     clock
//   i_reset   asynchronous reset, active low
//   i_flush   synchronous kill; abandons any operation in flight
//   i_start   ID/EX holds a valid DIV/DIVU/REM/REMU
//   i_op      00 DIV, 01 DIVU, 10 REM, 11 REMU
//   i_rs1     dividend (forwarded)
//   i_rs2     divisor (forwarded)
//   o_busy    stall request to IF/ID and ID/EX
//   o_done    one-cycle completion pulse
//   o_result  quotient or remainder, held until the next completion

module ex_div_unit #(
    parameter int XLEN = 32
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic            i_flush,
    input  logic            i_start,
    input  logic [1:0]      i_op,
    input  logic [XLEN-1:0] i_rs1,
    input  logic [XLEN-1:0] i_rs2,
    output logic            o_busy,
    output logic            o_done,
    output logic [XLEN-1:0] o_result
);

    localparam int              CW      = $clog2(XLEN);
    localparam logic [CW-1:0]   LAST    = CW'(XLEN - 1);
    localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t state;
    state_t state_next;

    logic [XLEN-1:0] quo;
    logic [XLEN-1:0] rem;
    logic [XLEN-1:0] divisor;
    logic [CW-1:0]   count;
    logic            rem_sel;
    logic            neg_quo;
    logic            neg_rem;
    logic [XLEN-1:0] result;

    // Decode of the incoming instruction. It is only used in the cycle
    // the operation is accepted.
    logic            is_signed;
    logic            rs1_neg;
    logic            rs2_neg;
    logic [XLEN-1:0] abs_rs1;
    logic [XLEN-1:0] abs_rs2;
    logic            div_zero;
    logic            overflow;
    logic            special;
    logic [XLEN-1:0] special_result;

    // One restoring step, plus the sign-fixed value used on the final step.
    logic [XLEN:0]   shifted;
    logic [XLEN:0]   trial;
    logic            fits;
    logic [XLEN-1:0] quo_step;
    logic [XLEN-1:0] rem_step;
    logic [XLEN-1:0] final_result;

    // Operand conditioning at start. Signed ops work on magnitudes. The two
    // architecturally defined corner cases get their results directly, so
    // the iteration loop never sees them.
    always_comb begin
        is_signed = ~i_op[0];
        rs1_neg   = is_signed & i_rs1[XLEN-1];
        rs2_neg   = is_signed & i_rs2[XLEN-1];
        abs_rs1   = rs1_neg ? -i_rs1 : i_rs1;
        abs_rs2   = rs2_neg ? -i_rs2 : i_rs2;
        div_zero  = (i_rs2 == '0);
        overflow  = is_signed & (i_rs1 == MIN_INT) & (i_rs2 == '1);
        special   = div_zero | overflow;
        if (div_zero) begin
            special_result = i_op[1] ? i_rs1 : '1;
        end else begin
            special_result = i_op[1] ? '0 : MIN_INT;
        end
    end

    // Shift {rem, quo} left by one, then trial-subtract the divisor with
    // one extra bit. A clear top bit means the divisor fit.
    always_comb begin
        shifted  = {rem, quo[XLEN-1]};
        trial    = shifted - {1'b0, divisor};
        fits     = ~trial[XLEN];
        rem_step = fits ? trial[XLEN-1:0] : shifted[XLEN-1:0];
        quo_step = {quo[XLEN-2:0], fits};
        if (rem_sel) begin
            final_result = neg_rem ? -rem_step : rem_step;
        end else begin
            final_result = neg_quo ? -quo_step : quo_step;
        end
    end

    // State register.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic. A flush wins over everything, including a start
    // presented in the same cycle.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (i_start) begin
                    state_next = special ? DONE : BUSY;
                end
            end
            BUSY: begin
                if (count == LAST) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        if (i_flush) begin
            state_next = IDLE;
        end
    end

    // Datapath registers. The result register is written only on the edge
    // that enters DONE, so it keeps its value across flushes and idle time.
    // i_start is not looked at in DONE, because the finished instruction is
    // still sitting in ID/EX during that cycle.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            quo     <= '0;
            rem     <= '0;
            divisor <= '0;
            count   <= '0;
            rem_sel <= 1'b0;
            neg_quo <= 1'b0;
            neg_rem <= 1'b0;
            result  <= '0;
        end else if (i_flush) begin
            count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_start) begin
                        rem_sel <= i_op[1];
                        neg_quo <= rs1_neg ^ rs2_neg;
                        neg_rem <= rs1_neg;
                        quo     <= abs_rs1;
                        divisor <= abs_rs2;
                        rem     <= '0;
                        count   <= '0;
                        if (special) begin
                            result <= special_result;
                        end
                    end
                end
                BUSY: begin
                    quo   <= quo_step;
                    rem   <= rem_step;
                    count <= count + 1'b1;
                    if (count == LAST) begin
                        result <= final_result;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // The stall request also covers the acceptance cycle, so that ID/EX
    // holds the instruction while the first iteration is set up. It is
    // forced low while reset is held.
    always_comb begin
        o_busy   = i_reset & (((state == IDLE) & i_start & ~i_flush) | (state == BUSY));
        o_done   = (state == DONE) & ~i_flush;
        o_result = result;
    end

endmodule

// File: tb/tb_ex_div_unit.sv
// tb_ex_div_unit
//   Directed-vector bench for ex_div_unit. Inputs are driven 1 time unit
//   after each rising edge and outputs are sampled 2 time units after it.
//   Cycle 0 is the cycle in which i_start is first presented.

module tb_ex_div_unit;

    logic        clk;
    logic        reset;
    logic        flush;
    logic        start;
    logic [1:0]  op;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int checks = 0;
    int errors = 0;

    ex_div_unit #(.XLEN(32)) dut (
        .i_clk    (clk),
        .i_reset  (reset),
        .i_flush  (flush),
        .i_start  (start),
        .i_op     (op),
        .i_rs1    (rs1),
        .i_rs2    (rs2),
        .o_busy   (busy),
        .o_done   (done),
        .o_result (result)
    );

    // 10-unit clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stop the run if something wedges outside the bounded loops.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Count one comparison and report it if it does not match.
    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
        end
    endtask

    // Advance to 1 unit after the next rising edge (the drive point).
    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    // Issue one operation. Operands are scrambled after cycle 0 to show
    // that they are latched. The task records the completion cycle, the
    // result, the number of stalled cycles, and o_busy in the done cycle.
    task automatic applyStimulus(input logic [1:0] op_in, input logic [31:0] a, input logic [31:0] b,
                                 output int done_cycle, output logic [31:0] res,
                                 output int busy_cycles, output logic busy_at_done);
        bit seen;
        int cyc;
        seen         = 0;
        cyc          = 0;
        done_cycle   = -1;
        res          = '0;
        busy_cycles  = 0;
        busy_at_done = 1'b1;
        start        = 1'b1;
        op           = op_in;
        rs1          = a;
        rs2          = b;
        while (!seen && cyc <= 40) begin
            #1;
            if (done) begin
                seen         = 1;
                done_cycle   = cyc;
                res          = result;
                busy_at_done = busy;
            end else if (busy) begin
                busy_cycles++;
            end
            nextCycle();
            cyc++;
            if (cyc == 1) begin
                rs1 = ~a;
                rs2 = b ^ 32'h0000_00F3;
            end
        end
        start = 1'b0;
    endtask

    // Run one vector and check its result, latency and stall window.
    task automatic runVector(input string tag, input logic [1:0] op_in, input logic [31:0] a,
                             input logic [31:0] b, input logic [31:0] exp_res, input int exp_cycle);
        int          dc;
        int          bc;
        logic [31:0] r;
        logic        bd;
        applyStimulus(op_in, a, b, dc, r, bc, bd);
        checkOutput({tag, "_result"}, r, exp_res);
        checkOutput({tag, "_done_cycle"}, 32'(dc), 32'(exp_cycle));
        checkOutput({tag, "_busy_cycles"}, 32'(bc), 32'(exp_cycle));
        checkOutput({tag, "_busy_at_done"}, {31'b0, bd}, 32'd0);
    endtask

    initial begin
        int          n_done;
        int          n_busy;
        int          c1;
        int          c2;
        logic [31:0] r1;
        logic [31:0] r2;

        reset = 1'b0;
        flush = 1'b0;
        start = 1'b0;
        op    = 2'b00;
        rs1   = '0;
        rs2   = '0;

        // Reset state.
        repeat (3) @(posedge clk);
        #2;
        checkOutput("reset_busy", {31'b0, busy}, 32'd0);
        checkOutput("reset_done", {31'b0, done}, 32'd0);
        checkOutput("reset_result", result, 32'd0);
        nextCycle();
        reset = 1'b1;
        nextCycle();

        // Normal and corner-case vectors.
        runVector("divu_100_7",     2'b01, 32'd100,       32'd7,         32'd14,        33);
        runVector("remu_100_7",     2'b11, 32'd100,       32'd7,         32'd2,         33);
        runVector("div_m7_2",       2'b00, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 33);
        runVector("rem_m7_2",       2'b10, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 33);
        runVector("div_7_m2",       2'b00, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 33);
        runVector("rem_7_m2",       2'b10, 32'd7,         32'hFFFF_FFFE, 32'd1,         33);
        runVector("div_m100_m7",    2'b00, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'd14,        33);
        runVector("rem_m100_m7",    2'b10, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 33);
        runVector("divu_max_16",    2'b01, 32'hFFFF_FFFF, 32'd16,        32'h0FFF_FFFF, 33);
        runVector("remu_max_16",    2'b11, 32'hFFFF_FFFF, 32'd16,        32'd15,        33);
        runVector("divu_min_max",   2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         33);
        runVector("remu_min_max",   2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 33);
        runVector("div_5_0",        2'b00, 32'd5,         32'd0,         32'hFFFF_FFFF, 1);
        runVector("rem_5_0",        2'b10, 32'd5,         32'd0,         32'd5,         1);
        runVector("divu_5_0",       2'b01, 32'd5,         32'd0,         32'hFFFF_FFFF, 1);
        runVector("remu_m5_0",      2'b11, 32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, 1);
        runVector("div_overflow",   2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
        runVector("rem_overflow",   2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1);

        // Back-to-back DIVU 20/3 then 9/4, with i_start held through DONE.
        // The second instruction arrives in ID/EX the cycle after DONE.
        n_done = 0;
        c1     = -1;
        c2     = -1;
        r1     = '0;
        r2     = '0;
        start  = 1'b1;
        op     = 2'b01;
        rs1    = 32'd20;
        rs2    = 32'd3;
        for (int cyc = 0; cyc <= 72; cyc++) begin
            #1;
            if (done) begin
                n_done++;
                if (n_done == 1) begin
                    c1 = cyc;
                    r1 = result;
                end else if (n_done == 2) begin
                    c2 = cyc;
                    r2 = result;
                end
            end
            nextCycle();
            if (n_done == 1 && cyc == c1) begin
                rs1 = 32'd9;
                rs2 = 32'd4;
            end
            if (n_done >= 2) begin
                break;
            end
        end
        start = 1'b0;
        checkOutput("b2b_first_cycle", 32'(c1), 32'd33);
        checkOutput("b2b_first_result", r1, 32'd6);
        checkOutput("b2b_second_cycle", 32'(c2), 32'd67);
        checkOutput("b2b_second_result", r2, 32'd2);
        checkOutput("b2b_done_count", 32'(n_done), 32'd2);

        // Flush at cycle 10 of a DIVU. The previous result (2) must survive.
        nextCycle();
        start = 1'b1;
        op    = 2'b01;
        rs1   = 32'd1000;
        rs2   = 32'd3;
        for (int cyc = 0; cyc < 10; cyc++) begin
            nextCycle();
        end
        flush = 1'b1;
        #1;
        checkOutput("flush_busy_before", {31'b0, busy}, 32'd1);
        nextCycle();
        flush = 1'b0;
        start = 1'b0;
        #1;
        checkOutput("flush_busy_after", {31'b0, busy}, 32'd0);
        n_done = 0;
        n_busy = 0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            if (done) n_done++;
            if (busy) n_busy++;
            nextCycle();
            #1;
        end
        checkOutput("flush_no_done", 32'(n_done), 32'd0);
        checkOutput("flush_idle", 32'(n_busy), 32'd0);
        checkOutput("flush_result_kept", result, 32'd2);

        // Flush has priority over a start in the same cycle.
        nextCycle();
        start = 1'b1;
        flush = 1'b1;
        op    = 2'b01;
        rs1   = 32'd50;
        rs2   = 32'd0;
        #1;
        checkOutput("flush_prio_busy", {31'b0, busy}, 32'd0);
        nextCycle();
        start = 1'b0;
        flush = 1'b0;
        #1;
        checkOutput("flush_prio_no_done", {31'b0, done}, 32'd0);
        checkOutput("flush_prio_result", result, 32'd2);

        // Asynchronous reset at cycle 15 of a DIV, with i_start still high.
        nextCycle();
        start = 1'b1;
        op    = 2'b00;
        rs1   = 32'hFFFF_FF9C;
        rs2   = 32'd7;
        for (int cyc = 0; cyc < 15; cyc++) begin
            nextCycle();
        end
        reset = 1'b0;
        #1;
        checkOutput("areset_busy", {31'b0, busy}, 32'd0);
        checkOutput("areset_done", {31'b0, done}, 32'd0);
        checkOutput("areset_result", result, 32'd0);
        start = 1'b0;
        nextCycle();
        nextCycle();
        reset = 1'b1;
        n_done = 0;
        n_busy = 0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            nextCycle();
            #1;
            if (done) n_done++;
            if (busy) n_busy++;
        end
        checkOutput("areset_no_done", 32'(n_done), 32'd0);
        checkOutput("areset_idle", 32'(n_busy), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
